// File: rtl/fpmul_pkg.sv
// Shared types, flag positions and width helpers for the parametrised
// floating-point multiplier and its rounding/packing stage.
package fpmul_pkg;

  typedef enum logic [2:0] {
    ZERO,
    NORM,
    INF,
    QNAN,
    SNAN
  } fp_class_e;

  localparam int FLAG_W         = 4;
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int word_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  // Wide enough for any sensible format; callers keep the low word_w() bits.
  function automatic logic [127:0] canon_nan(input int exp_w, input int man_w);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++) begin
      v[man_w + i] = 1'b1;
    end
    v[man_w - 1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Normalises a raw significand product by 0/1 shift, rounds to nearest-even,
// renormalises on carry-out and packs the result with overflow/underflow handling.
module fp_round_pack import fpmul_pkg::*; #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W  = word_w(EXP_W, MAN_W),
  localparam int PW = 2 * MAN_W + 2
) (
  input  logic                    sign,
  input  logic signed [EXP_W+1:0] exp_sum,
  input  logic [PW-1:0]           prod,
  output logic [W-1:0]            result,
  output logic [FLAG_W-1:0]       flags
);

  localparam logic signed [EXP_W+1:0] EXP_ONE = {{(EXP_W+1){1'b0}}, 1'b1};
  localparam logic signed [EXP_W+1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};

  logic [PW-1:0]           norm;
  logic signed [EXP_W+1:0] exp_n;
  logic signed [EXP_W+1:0] exp_f;
  logic [MAN_W-1:0]        mant;
  logic                    guard;
  logic                    sticky;
  logic                    round_up;
  logic [MAN_W:0]          mant_r;

  // The product of two [1,2) significands lies in [1,4), so at most one shift.
  always_comb begin
    norm     = prod[PW-1] ? prod : (prod << 1);
    exp_n    = prod[PW-1] ? (exp_sum + EXP_ONE) : exp_sum;
    mant     = norm[PW-2 -: MAN_W];
    guard    = norm[MAN_W];
    sticky   = |norm[MAN_W-1:0];
    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + {{MAN_W{1'b0}}, round_up};
    exp_f    = mant_r[MAN_W] ? (exp_n + EXP_ONE) : exp_n;

    result = {sign, exp_f[EXP_W-1:0], mant_r[MAN_W-1:0]};
    flags  = '0;
    flags[FLAG_INEXACT] = guard | sticky;

    if (!exp_f[EXP_W+1] && (exp_f >= EXP_MAX)) begin
      result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags[FLAG_OVERFLOW] = 1'b1;
      flags[FLAG_INEXACT]  = 1'b1;
    end else if (exp_f[EXP_W+1] || (exp_f == '0)) begin
      result = {sign, {(W-1){1'b0}}};
      flags[FLAG_UNDERFLOW] = 1'b1;
      flags[FLAG_INEXACT]   = 1'b1;
    end
  end

endmodule

// File: rtl/fpmul_pipe.sv
// Pipelined IEEE-754 multiplier with valid/ready backpressure, RNE rounding and
// exception flags; operands and results are registered at the block boundary.
module fpmul_pipe import fpmul_pkg::*; #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W  = word_w(EXP_W, MAN_W),
  localparam int SW = MAN_W + 1,
  localparam int PW = 2 * SW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      reg_A,
  input  logic [W-1:0]      reg_B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out,
  output logic [FLAG_W-1:0] flags
);

  localparam logic [EXP_W+1:0] BIAS_X    = (EXP_W+2)'(bias_of(EXP_W));
  localparam logic [127:0]     CNAN_WIDE = canon_nan(EXP_W, MAN_W);
  localparam logic [W-1:0]     CNAN      = CNAN_WIDE[W-1:0];
  localparam logic [W-2:0]     INF_MAG   = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

  function automatic fp_class_e classify(input logic [W-1:0] v);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    e = v[W-2 -: EXP_W];
    f = v[MAN_W-1:0];
    if (e == '0) return ZERO;
    if (&e) begin
      if (f == '0) return INF;
      return f[MAN_W-1] ? QNAN : SNAN;
    end
    return NORM;
  endfunction

  logic advance;

  logic                    s1_valid;
  logic [W-1:0]            s1_a;
  logic [W-1:0]            s1_b;
  fp_class_e               s1_cls_a;
  fp_class_e               s1_cls_b;
  logic                    s1_sign;
  logic signed [EXP_W+1:0] s1_esum;
  logic [SW-1:0]           s1_sig_a;
  logic [SW-1:0]           s1_sig_b;

  logic                    s2_valid;
  fp_class_e               s2_cls_a;
  fp_class_e               s2_cls_b;
  logic                    s2_sign;
  logic signed [EXP_W+1:0] s2_esum;
  logic [SW-1:0]           s2_sig_a;
  logic [SW-1:0]           s2_sig_b;
  logic [PW-1:0]           s2_prod;

  logic                    s3_valid;
  fp_class_e               s3_cls_a;
  fp_class_e               s3_cls_b;
  logic                    s3_sign;
  logic signed [EXP_W+1:0] s3_esum;
  logic [PW-1:0]           s3_prod;
  logic [W-1:0]            rp_result;
  logic [FLAG_W-1:0]       rp_flags;
  logic [W-1:0]            s3_result;
  logic [FLAG_W-1:0]       s3_flags;
  logic                    any_nan;
  logic                    inf_zero;
  logic                    any_snan;

  // The whole pipe freezes only when a finished result is being refused.
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  always_comb begin
    s1_cls_a = classify(s1_a);
    s1_cls_b = classify(s1_b);
    s1_sign  = s1_a[W-1] ^ s1_b[W-1];
    s1_esum  = {2'b00, s1_a[W-2 -: EXP_W]} + {2'b00, s1_b[W-2 -: EXP_W]} - BIAS_X;
    s1_sig_a = {1'b1, s1_a[MAN_W-1:0]};
    s1_sig_b = {1'b1, s1_b[MAN_W-1:0]};
  end

  assign s2_prod = s2_sig_a * s2_sig_b;

  fp_round_pack #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_pack (
    .sign    (s3_sign),
    .exp_sum (s3_esum),
    .prod    (s3_prod),
    .result  (rp_result),
    .flags   (rp_flags)
  );

  // Special operands override the rounded path in NaN, Inf, zero priority.
  always_comb begin
    any_nan  = (s3_cls_a == QNAN) || (s3_cls_a == SNAN) ||
               (s3_cls_b == QNAN) || (s3_cls_b == SNAN);
    any_snan = (s3_cls_a == SNAN) || (s3_cls_b == SNAN);
    inf_zero = ((s3_cls_a == INF) && (s3_cls_b == ZERO)) ||
               ((s3_cls_a == ZERO) && (s3_cls_b == INF));
    s3_result = rp_result;
    s3_flags  = rp_flags;
    if (any_nan || inf_zero) begin
      s3_result = CNAN;
      s3_flags  = '0;
      s3_flags[FLAG_INVALID] = inf_zero | any_snan;
    end else if ((s3_cls_a == INF) || (s3_cls_b == INF)) begin
      s3_result = {s3_sign, INF_MAG};
      s3_flags  = '0;
    end else if ((s3_cls_a == ZERO) || (s3_cls_b == ZERO)) begin
      s3_result = {s3_sign, {(W-1){1'b0}}};
      s3_flags  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s2_valid  <= 1'b0;
      s2_cls_a  <= ZERO;
      s2_cls_b  <= ZERO;
      s2_sign   <= 1'b0;
      s2_esum   <= '0;
      s2_sig_a  <= '0;
      s2_sig_b  <= '0;
      s3_valid  <= 1'b0;
      s3_cls_a  <= ZERO;
      s3_cls_b  <= ZERO;
      s3_sign   <= 1'b0;
      s3_esum   <= '0;
      s3_prod   <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      flags     <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a <= reg_A;
        s1_b <= reg_B;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_cls_a <= s1_cls_a;
        s2_cls_b <= s1_cls_b;
        s2_sign  <= s1_sign;
        s2_esum  <= s1_esum;
        s2_sig_a <= s1_sig_a;
        s2_sig_b <= s1_sig_b;
      end
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_cls_a <= s2_cls_a;
        s3_cls_b <= s2_cls_b;
        s3_sign  <= s2_sign;
        s3_esum  <= s2_esum;
        s3_prod  <= s2_prod;
      end
      out_valid <= s3_valid;
      if (s3_valid) begin
        out   <= s3_result;
        flags <= s3_flags;
      end
    end
  end

endmodule
